// File: rtl/inport_ctrl.sv
// Input port controller: synchronizes and debounces an external strobe, captures the
// device word into a holding register and hands it to the control unit with a read handshake.
module inport_ctrl #(
   parameter int unsigned          DATA_WIDTH      = 32,
   parameter int unsigned          SYNC_STAGES     = 2,
   parameter int unsigned          DEBOUNCE_CYCLES = 4,
   parameter logic [DATA_WIDTH-1:0] INIT           = '0
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  ext_strobe,
   input  logic [DATA_WIDTH-1:0] External_Input,
   input  logic                  rd_req,
   input  logic                  ovr_clr,
   output logic [DATA_WIDTH-1:0] BusMuxIn,
   output logic                  data_ready,
   output logic                  rd_ack,
   output logic                  stall,
   output logic                  overrun
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      FULL     = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LOAD = 8'(DEBOUNCE_CYCLES - 1);

   state_t                 state;
   state_t                 state_next;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   s_prev;
   logic                   rise;
   logic [7:0]             cnt;

   logic                   cnt_load;
   logic                   cnt_dec;
   logic                   capture;
   logic                   ack_set;
   logic                   ovr_set;

   // Strobe synchronizer; s_prev lets a level held across capture/read never re-trigger.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         sync_q <= '0;
         s_prev <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values, forming a true shift chain.
         sync_q <= {sync_q[SYNC_STAGES-2:0], ext_strobe};
         s_prev <= s;
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s && !s_prev;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch is inferred.
      state_next = state;
      case (state)
         IDLE: begin
            if (rise) state_next = DEBOUNCE;
         end
         DEBOUNCE: begin
            if (!s)             state_next = IDLE;
            else if (cnt == '0) state_next = FULL;
         end
         FULL: begin
            if (rd_req) state_next = rise ? DEBOUNCE : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      capture  = 1'b0;
      ack_set  = 1'b0;
      ovr_set  = 1'b0;
      case (state)
         IDLE: begin
            cnt_load = rise;
         end
         DEBOUNCE: begin
            if (s) begin
               if (cnt == '0) capture = 1'b1;
               else           cnt_dec = 1'b1;
            end
         end
         FULL: begin
            ack_set = rd_req;
            // A new strobe while full is either the next word (read this edge) or an overrun.
            if (rise) begin
               if (rd_req) cnt_load = 1'b1;
               else        ovr_set  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         cnt      <= '0;
         rd_ack   <= 1'b0;
         overrun  <= 1'b0;
         // NOTE: the holding register is a plain register, not a memory, so it resets to INIT like any flop.
         BusMuxIn <= INIT;
      end else begin
         if (cnt_load)     cnt <= CNT_LOAD;
         else if (cnt_dec) cnt <= cnt - 8'd1;

         rd_ack <= ack_set;

         if (ovr_set)      overrun <= 1'b1;
         else if (ovr_clr) overrun <= 1'b0;

         if (capture) BusMuxIn <= External_Input;
      end
   end

   assign data_ready = (state == FULL);
   assign stall      = rd_req && !data_ready && !rd_ack;

endmodule

// File: tb/tb_inport_ctrl.sv
// Scenario bench for inport_ctrl: expected words are queued when strobed and checked by a
// monitor whenever rd_ack reports a consumed word.
module tb_inport_ctrl;

   localparam int DW = 32;
   localparam logic [DW-1:0] INIT_VAL = '0;

   logic          clock = 1'b0;
   logic          clear;
   logic          ext_strobe;
   logic [DW-1:0] External_Input;
   logic          rd_req;
   logic          ovr_clr;
   logic [DW-1:0] BusMuxIn;
   logic          data_ready;
   logic          rd_ack;
   logic          stall;
   logic          overrun;

   int            vectors     = 0;
   int            miscompares = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] sb_exp;
   logic [DW-1:0] sb_drop;

   always #5 clock = ~clock;

   inport_ctrl #(
      .DATA_WIDTH(DW),
      .SYNC_STAGES(2),
      .DEBOUNCE_CYCLES(4),
      .INIT(INIT_VAL)
   ) dut (
      .clock(clock),
      .clear(clear),
      .ext_strobe(ext_strobe),
      .External_Input(External_Input),
      .rd_req(rd_req),
      .ovr_clr(ovr_clr),
      .BusMuxIn(BusMuxIn),
      .data_ready(data_ready),
      .rd_ack(rd_ack),
      .stall(stall),
      .overrun(overrun)
   );

   // Scoreboard monitor: each rd_ack must consume exactly one queued word.
   initial begin
      forever begin
         @(posedge clock);
         #2;
         if (rd_ack === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL sb_unexpected_ack: rd_ack=1 with BusMuxIn=%h, required no ack (nothing queued)", BusMuxIn);
            end else begin
               sb_exp = exp_q.pop_front();
               if (BusMuxIn !== sb_exp) begin
                  miscompares++;
                  $display("FAIL sb_word: BusMuxIn=%h required %h", BusMuxIn, sb_exp);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      clear          = 1'b1;
      ext_strobe     = 1'b0;
      rd_req         = 1'b0;
      ovr_clr        = 1'b0;
      External_Input = '0;
      tick();
      tick();
      clear = 1'b0;
   endtask

   task automatic wait_ready(input int max_cycles, input string name);
      int n = 0;
      while (data_ready !== 1'b1 && n < max_cycles) begin
         tick();
         n++;
      end
      vectors++;
      if (data_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s: data_ready=%b after %0d cycles, required 1", name, data_ready, n);
      end
   endtask

   task automatic read_word(input string name);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      vectors++;
      if (rd_ack !== 1'b1) begin miscompares++; $display("FAIL %s_ack: rd_ack=%b required 1", name, rd_ack); end
      vectors++;
      if (data_ready !== 1'b0) begin miscompares++; $display("FAIL %s_drained: data_ready=%b required 0", name, data_ready); end
      tick();
      vectors++;
      if (rd_ack !== 1'b0) begin miscompares++; $display("FAIL %s_ack_pulse: rd_ack=%b required 0", name, rd_ack); end
   endtask

   task automatic test_reset();
      #3;
      vectors++;
      if (BusMuxIn !== INIT_VAL) begin miscompares++; $display("FAIL rst_bus: BusMuxIn=%h required %h", BusMuxIn, INIT_VAL); end
      vectors++;
      if (data_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: data_ready=%b required 0", data_ready); end
      vectors++;
      if (rd_ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack: rd_ack=%b required 0", rd_ack); end
      vectors++;
      if (overrun !== 1'b0) begin miscompares++; $display("FAIL rst_ovr: overrun=%b required 0", overrun); end
      vectors++;
      if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall: stall=%b required 0", stall); end
      tick();
      tick();
      clear = 1'b0;
   endtask

   task automatic test_capture_read();
      External_Input = 32'hDEADBEEF;
      ext_strobe     = 1'b1;
      exp_q.push_back(32'hDEADBEEF);
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 6) begin
            vectors++;
            if (data_ready !== 1'b0) begin miscompares++; $display("FAIL cap_early: data_ready=%b at edge 6, required 0", data_ready); end
         end
         if (i == 7 || i == 10) begin
            vectors++;
            if (data_ready !== 1'b1) begin miscompares++; $display("FAIL cap_ready_e%0d: data_ready=%b required 1", i, data_ready); end
            vectors++;
            if (BusMuxIn !== 32'hDEADBEEF) begin miscompares++; $display("FAIL cap_bus_e%0d: BusMuxIn=%h required deadbeef", i, BusMuxIn); end
         end
      end
      ext_strobe = 1'b0;
      read_word("cap_read");
      vectors++;
      if (BusMuxIn !== 32'hDEADBEEF) begin miscompares++; $display("FAIL cap_bus_after_read: BusMuxIn=%h required deadbeef", BusMuxIn); end
      repeat (3) tick();
   endtask

   task automatic test_glitch();
      apply_reset();
      External_Input = 32'h5555_5555;
      ext_strobe     = 1'b1;
      repeat (3) tick();
      ext_strobe = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         vectors++;
         if (data_ready !== 1'b0) begin miscompares++; $display("FAIL glitch_ready_%0d: data_ready=%b required 0", i, data_ready); end
      end
      vectors++;
      if (BusMuxIn !== INIT_VAL) begin miscompares++; $display("FAIL glitch_bus: BusMuxIn=%h required %h", BusMuxIn, INIT_VAL); end
   endtask

   task automatic test_stall();
      apply_reset();
      rd_req = 1'b1;
      #0;
      vectors++;
      if (stall !== 1'b1) begin miscompares++; $display("FAIL stall_idle: stall=%b required 1", stall); end
      External_Input = 32'h12;
      ext_strobe     = 1'b1;
      exp_q.push_back(32'h12);
      for (int i = 1; i <= 9; i++) begin
         tick();
         if (i <= 6) begin
            vectors++;
            if (stall !== 1'b1 || data_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL stall_wait_e%0d: stall=%b data_ready=%b required 1/0", i, stall, data_ready);
            end
         end else if (i == 7) begin
            vectors++;
            if (stall !== 1'b0 || data_ready !== 1'b1) begin
               miscompares++;
               $display("FAIL stall_capture: stall=%b data_ready=%b required 0/1", stall, data_ready);
            end
         end else if (i == 8) begin
            vectors++;
            if (rd_ack !== 1'b1 || stall !== 1'b0 || data_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL stall_ack: rd_ack=%b stall=%b data_ready=%b required 1/0/0", rd_ack, stall, data_ready);
            end
         end else begin
            vectors++;
            if (rd_ack !== 1'b0 || stall !== 1'b1) begin
               miscompares++;
               $display("FAIL stall_after: rd_ack=%b stall=%b required 0/1", rd_ack, stall);
            end
         end
      end
      rd_req     = 1'b0;
      ext_strobe = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_overrun();
      apply_reset();
      External_Input = 32'hA;
      ext_strobe     = 1'b1;
      exp_q.push_back(32'hA);
      repeat (6) tick();
      ext_strobe = 1'b0;
      wait_ready(10, "ovr_first_ready");
      repeat (4) tick();
      External_Input = 32'hB;
      ext_strobe     = 1'b1;
      repeat (4) tick();
      ext_strobe = 1'b0;
      vectors++;
      if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set: overrun=%b required 1", overrun); end
      vectors++;
      if (BusMuxIn !== 32'hA || data_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ovr_hold: BusMuxIn=%h data_ready=%b required 0000000a/1", BusMuxIn, data_ready);
      end
      repeat (3) tick();
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      vectors++;
      if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clr: overrun=%b required 0", overrun); end
      // Rise and ovr_clr on the same edge: set must win.
      ext_strobe = 1'b1;
      tick();
      tick();
      vectors++;
      if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_pre_race: overrun=%b required 0", overrun); end
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      vectors++;
      if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set_wins: overrun=%b required 1", overrun); end
      ext_strobe = 1'b0;
      repeat (3) tick();
      read_word("ovr_read");
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      External_Input = 32'hCCCC_0001;
      ext_strobe     = 1'b1;
      exp_q.push_back(32'hCCCC_0001);
      repeat (6) tick();
      ext_strobe = 1'b0;
      wait_ready(10, "b2b_first_ready");
      repeat (4) tick();
      External_Input = 32'hDDDD_0002;
      ext_strobe     = 1'b1;
      exp_q.push_back(32'hDDDD_0002);
      tick();
      tick();
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      vectors++;
      if (rd_ack !== 1'b1 || overrun !== 1'b0 || data_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_coincident: rd_ack=%b overrun=%b data_ready=%b required 1/0/0", rd_ack, overrun, data_ready);
      end
      for (int i = 1; i <= 4; i++) begin
         tick();
         vectors++;
         if (data_ready !== (i == 4)) begin
            miscompares++;
            $display("FAIL b2b_ready_e%0d: data_ready=%b required %b", i, data_ready, (i == 4));
         end
      end
      vectors++;
      if (BusMuxIn !== 32'hDDDD_0002) begin miscompares++; $display("FAIL b2b_bus: BusMuxIn=%h required dddd0002", BusMuxIn); end
      ext_strobe = 1'b0;
      read_word("b2b_read");
      repeat (3) tick();
   endtask

   task automatic test_clear();
      apply_reset();
      External_Input = 32'hEEEE_0003;
      ext_strobe     = 1'b1;
      repeat (4) tick();
      #3;
      clear = 1'b1;
      #1;
      vectors++;
      if (data_ready !== 1'b0 || rd_ack !== 1'b0 || overrun !== 1'b0 || BusMuxIn !== INIT_VAL) begin
         miscompares++;
         $display("FAIL clr_debounce: ready=%b ack=%b ovr=%b bus=%h required 0/0/0/%h", data_ready, rd_ack, overrun, BusMuxIn, INIT_VAL);
      end
      ext_strobe = 1'b0;
      tick();
      tick();
      clear = 1'b0;
      repeat (10) tick();
      vectors++;
      if (data_ready !== 1'b0) begin miscompares++; $display("FAIL clr_no_capture: data_ready=%b required 0", data_ready); end

      External_Input = 32'hFFFF_0004;
      ext_strobe     = 1'b1;
      exp_q.push_back(32'hFFFF_0004);
      repeat (6) tick();
      ext_strobe = 1'b0;
      wait_ready(10, "clr_full_ready");
      repeat (4) tick();
      ext_strobe = 1'b1;
      repeat (4) tick();
      ext_strobe = 1'b0;
      vectors++;
      if (overrun !== 1'b1) begin miscompares++; $display("FAIL clr_pre_ovr: overrun=%b required 1", overrun); end
      #3;
      clear   = 1'b1;
      sb_drop = exp_q.pop_back();
      #1;
      vectors++;
      if (data_ready !== 1'b0 || overrun !== 1'b0 || BusMuxIn !== INIT_VAL) begin
         miscompares++;
         $display("FAIL clr_full: ready=%b ovr=%b bus=%h required 0/0/%h", data_ready, overrun, BusMuxIn, INIT_VAL);
      end
      tick();
      clear  = 1'b0;
      rd_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (rd_ack !== 1'b0 || stall !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_no_ack_%0d: rd_ack=%b stall=%b required 0/1", i, rd_ack, stall);
         end
      end
      rd_req = 1'b0;
      tick();
   endtask

   task automatic test_strobe_through_reset();
      clear          = 1'b1;
      ext_strobe     = 1'b1;
      External_Input = 32'h0BAD_F00D;
      exp_q.push_back(32'h0BAD_F00D);
      tick();
      tick();
      clear = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         if (i == 6) begin
            vectors++;
            if (data_ready !== 1'b0) begin miscompares++; $display("FAIL str_rst_early: data_ready=%b required 0", data_ready); end
         end
         if (i == 7) begin
            vectors++;
            if (data_ready !== 1'b1 || BusMuxIn !== 32'h0BAD_F00D) begin
               miscompares++;
               $display("FAIL str_rst_capture: ready=%b bus=%h required 1/0badf00d", data_ready, BusMuxIn);
            end
         end
      end
      ext_strobe = 1'b0;
      read_word("str_rst_read");
   endtask

   initial begin
      clear          = 1'b1;
      ext_strobe     = 1'b0;
      rd_req         = 1'b0;
      ovr_clr        = 1'b0;
      External_Input = '0;
      test_reset();
      test_capture_read();
      test_glitch();
      test_stall();
      test_overrun();
      test_back_to_back();
      test_clear();
      test_strobe_through_reset();
      repeat (3) tick();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL sb_drained: %0d words never acknowledged, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
